// File: rtl/uart_byte_rx_pkg.sv
// Shared UART receiver definitions: baud codes, frame constants, FSM states
// and the oversample divider computation shared with the transmitter.
package uart_byte_rx_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned SAMPLE_LO  = 7;
   localparam int unsigned DIV_W      = 16;
   localparam int unsigned TICK_W     = 8;

   localparam logic [2:0] BAUD_9600   = 3'd0;
   localparam logic [2:0] BAUD_19200  = 3'd1;
   localparam logic [2:0] BAUD_38400  = 3'd2;
   localparam logic [2:0] BAUD_57600  = 3'd3;
   localparam logic [2:0] BAUD_115200 = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_e;

   // Oversample divider terminal count, integer truncation.
   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / (baud * OVERSAMPLE) - 1;
   endfunction

endpackage

// File: rtl/uart_rx_bps_gen.sv
// Oversample tick generator: latches the rate code on clear and divides clk
// down to a 16x-baud tick while enabled.
module uart_rx_bps_gen
   import uart_byte_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic [2:0] baud_set,
   output logic       tick_c
);

   localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(calc_div(CLK_FREQ, 32'd9600));
   localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(calc_div(CLK_FREQ, 32'd19200));
   localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(calc_div(CLK_FREQ, 32'd38400));
   localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(calc_div(CLK_FREQ, 32'd57600));
   localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(calc_div(CLK_FREQ, 32'd115200));

   logic [2:0]       baud_q;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_max;

   // Unlisted codes fall back to 9600.
   always_comb begin
      div_max = DIV_9600;
      case (baud_q)
         BAUD_19200:  div_max = DIV_19200;
         BAUD_38400:  div_max = DIV_38400;
         BAUD_57600:  div_max = DIV_57600;
         BAUD_115200: div_max = DIV_115200;
         default:     div_max = DIV_9600;
      endcase
   end

   assign tick_c = en && (div_cnt == div_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q  <= BAUD_9600;
         div_cnt <= '0;
      end else if (clr) begin
         baud_q  <= baud_set;
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling and 3-sample majority vote;
// emits each byte with a one-cycle rx_done strobe and a stop-bit error flag.
module uart_byte_rx
   import uart_byte_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic [2:0] baud_set,
   output logic [7:0] data_byte,
   output logic       rx_done,
   output logic       frame_err,
   output logic       uart_state
);

   logic                 rx_s1, rx_s2, rx_d;
   rx_state_e            state;
   logic [TICK_W-1:0]    tick_cnt;
   logic [1:0]           smp;
   logic [DATA_BITS-1:0] shreg;
   logic                 tick_c, fall_c, start_c, vote_c, vote_now_c;
   logic [3:0]           phase_c, bit_idx_c;

   assign fall_c     = rx_d & ~rx_s2;
   assign start_c    = (state == ST_IDLE) && fall_c;
   assign phase_c    = tick_cnt[3:0];
   assign bit_idx_c  = tick_cnt[7:4];
   assign vote_c     = (smp[0] & smp[1]) | (smp[0] & rx_s2) | (smp[1] & rx_s2);
   assign vote_now_c = tick_c && (phase_c == 4'(SAMPLE_LO + 2));

   uart_rx_bps_gen #(
      .CLK_FREQ (CLK_FREQ)
   ) u_bps_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state != ST_IDLE),
      .clr      (start_c),
      .baud_set (baud_set),
      .tick_c   (tick_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_d       <= 1'b1;
         state      <= ST_IDLE;
         tick_cnt   <= '0;
         smp        <= '0;
         shreg      <= '0;
         data_byte  <= '0;
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         uart_state <= 1'b0;
      end else begin
         rx_s1     <= rx;
         rx_s2     <= rx_s1;
         rx_d      <= rx_s2;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;

         // First two of the three votes are held; the third is the live sample.
         if (state != ST_IDLE && tick_c) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            if (phase_c == 4'(SAMPLE_LO))     smp[0] <= rx_s2;
            if (phase_c == 4'(SAMPLE_LO + 1)) smp[1] <= rx_s2;
         end

         case (state)
            ST_IDLE: begin
               uart_state <= fall_c;
               if (fall_c) begin
                  state    <= ST_START;
                  tick_cnt <= '0;
               end
            end
            ST_START: begin
               if (vote_now_c) begin
                  if (vote_c) begin
                     state      <= ST_IDLE;
                     uart_state <= 1'b0;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (vote_now_c) begin
                  shreg[3'(bit_idx_c - 4'd1)] <= vote_c;
                  if (bit_idx_c == 4'(DATA_BITS)) state <= ST_STOP;
               end
            end
            ST_STOP: begin
               // Leave mid stop bit so the next start edge is never missed.
               if (vote_now_c) begin
                  data_byte <= shreg;
                  frame_err <= ~vote_c;
                  rx_done   <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: stimulus pushes expected bytes, a monitor
// pops and compares on every rx_done strobe.
module tb_uart_byte_rx;

   localparam int BIT_FAST  = 432;
   localparam int BIT_SLOW  = 5200;
   localparam int NOISE_OFS = 243;

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [2:0] baud_set;
   logic [7:0] data_byte;
   logic       rx_done;
   logic       frame_err;
   logic       uart_state;

   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   uart_byte_rx #(.CLK_FREQ(50_000_000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .baud_set   (baud_set),
      .data_byte  (data_byte),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .uart_state (uart_state)
   );

   always #10 clk = ~clk;

   // Monitor: every rx_done cycle must match the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && rx_done) begin
         done_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rx_done got data=%h ferr=%b expected no frame", data_byte, frame_err);
         end else begin
            mon_e = exp_q.pop_front();
            if (data_byte !== mon_e.data || frame_err !== mon_e.ferr) begin
               errors++;
               $display("FAIL rx_frame got data=%h ferr=%b expected data=%h ferr=%b",
                        data_byte, frame_err, mon_e.data, mon_e.ferr);
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame starting at a negedge; optional 1-clock noise pulse
   // on the tick-8 sample of every bit and optional busy check mid-bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_clks,
                             input bit noise, input bit chk_state);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         for (int j = 1; j < bit_clks; j++) begin
            @(negedge clk);
            rx = (noise && j == NOISE_OFS) ? ~f[i] : f[i];
            if (chk_state && j == bit_clks / 2) check("uart_state_busy", {7'd0, uart_state}, 8'd1);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [9:0] rf;
      rst_n    = 1'b0;
      rx       = 1'b1;
      baud_set = 3'd4;
      idle(5);
      check("reset_data_byte", data_byte, 8'h00);
      check("reset_rx_done", {7'd0, rx_done}, 8'd0);
      check("reset_frame_err", {7'd0, frame_err}, 8'd0);
      check("reset_uart_state", {7'd0, uart_state}, 8'd0);
      rst_n = 1'b1;
      idle(20);
      check("idle_uart_state", {7'd0, uart_state}, 8'd0);

      // Nominal byte at 115200.
      exp_q.push_back('{data: 8'hA5, ferr: 1'b0});
      send_frame(8'hA5, 1'b1, BIT_FAST, 1'b0, 1'b1);
      idle(50);
      check("nominal_hold", data_byte, 8'hA5);
      check("nominal_state_idle", {7'd0, uart_state}, 8'd0);

      // Short low glitch is a false start.
      rx = 1'b0;
      idle(100);
      rx = 1'b1;
      idle(200);
      check("glitch_state_idle", {7'd0, uart_state}, 8'd0);
      check("glitch_hold", data_byte, 8'hA5);

      // Framing error: stop bit low.
      exp_q.push_back('{data: 8'h3C, ferr: 1'b1});
      send_frame(8'h3C, 1'b0, BIT_FAST, 1'b0, 1'b0);
      rx = 1'b1;
      idle(50);
      check("ferr_hold", data_byte, 8'h3C);
      check("ferr_one_cycle", {7'd0, frame_err}, 8'd0);

      // Back-to-back frames, no idle gap.
      exp_q.push_back('{data: 8'h00, ferr: 1'b0});
      exp_q.push_back('{data: 8'hFF, ferr: 1'b0});
      send_frame(8'h00, 1'b1, BIT_FAST, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, BIT_FAST, 1'b0, 1'b0);
      idle(50);

      // Single-clock noise on a sample point of every bit.
      exp_q.push_back('{data: 8'h96, ferr: 1'b0});
      send_frame(8'h96, 1'b1, BIT_FAST, 1'b1, 1'b0);
      idle(50);
      check("noise_hold", data_byte, 8'h96);

      // 9600 with rate code changed mid-frame.
      baud_set = 3'd0;
      exp_q.push_back('{data: 8'h5A, ferr: 1'b0});
      fork
         send_frame(8'h5A, 1'b1, BIT_SLOW, 1'b0, 1'b0);
         begin
            idle(BIT_SLOW * 4);
            baud_set = 3'd4;
         end
      join
      idle(50);
      check("slow_hold", data_byte, 8'h5A);

      // Reset during data bit 4 aborts the frame.
      rf = {1'b1, 8'hC3, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx = rf[i];
         idle(BIT_FAST);
      end
      rx = rf[5];
      idle(200);
      check("busy_before_reset", {7'd0, uart_state}, 8'd1);
      rst_n = 1'b0;
      #1;
      check("midreset_data_byte", data_byte, 8'h00);
      check("midreset_rx_done", {7'd0, rx_done}, 8'd0);
      check("midreset_frame_err", {7'd0, frame_err}, 8'd0);
      check("midreset_uart_state", {7'd0, uart_state}, 8'd0);
      idle(10);
      rx = 1'b1;
      idle(10);
      rst_n = 1'b1;
      idle(100);
      exp_q.push_back('{data: 8'h81, ferr: 1'b0});
      send_frame(8'h81, 1'b1, BIT_FAST, 1'b0, 1'b0);
      idle(100);
      check("post_reset_hold", data_byte, 8'h81);

      check("pending_frames", 8'(exp_q.size()), 8'd0);
      check("rx_done_count", 8'(done_cnt), 8'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
